fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage for the single-cycle/pipelined MIPS core, sitting directly upstream of the instruction memory.
- Owns the PC and drives the memory word address; the memory returns the instruction combinationally in the same cycle.
- Captures the instruction into the IF/ID register, resolves J instructions locally with no bubble, and accepts stall and redirect from downstream.

Parameters:
- ADDR_W, 8: PC / instruction-memory word-address width.
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC value on reset.
- JUMP_OPCODE, 6'b000010: opcode field value recognised as J.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- imem_addr  output  ADDR_W  word address to instruction memory; equals pc.
- imem_data  input  DATA_W  instruction read combinationally at imem_addr.
- stall  input  1  hold PC and IF/ID.
- redirect_valid  input  1  taken-branch redirect from downstream.
- redirect_target  input  ADDR_W  new PC for redirect.
- ifid_instr  output  DATA_W  registered instruction.
- ifid_pc  output  ADDR_W  PC of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real instruction.
- fetch_count  output  16  instructions delivered; saturating.
- halted  output  1  self-jump halt detected.

Behaviour:
- Clocking: all state updates on posedge clk; rst is synchronous and active-high.
- Reset values: pc=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, fetch_count=0, halted=0, state=BOOT. Redirect and stall are ignored while rst=1.
- imem_addr = pc, combinational; no added latency.
- FSM states:
  - BOOT: one cycle after rst deasserts, so memory contents loaded at the reset edge are settled. pc holds, ifid_valid=0. Goes to RUN unconditionally; a redirect in BOOT is still taken.
  - RUN: normal fetch.
  - HALT: only with the macro enabled.
- RUN update priority, highest first:
  - redirect_valid=1:
    - pc<=redirect_target.
    - ifid_valid<=0, ifid_instr<=0 (flush).
    - Wins over stall and over a jump in the same cycle.
  - stall=1: pc, ifid_*, fetch_count hold.
  - Otherwise:
    - ifid_instr<=imem_data, ifid_pc<=pc, ifid_valid<=1, fetch_count++ (saturates at 16'hFFFF).
    - If imem_data[31:26]==JUMP_OPCODE: pc<=imem_data[ADDR_W-1:0].
    - Else pc<=pc+1, wrapping modulo 2^ADDR_W (255 to 0).
- A J instruction is still delivered to IF/ID with ifid_valid=1; decode must not redirect for J.
- Branches (BEQ) are resolved downstream and arrive via redirect_valid; the fetch stage does no prediction.
- Reset asserted mid-operation: all state returns to reset values on that edge; any in-flight IF/ID contents are discarded.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Enabled, entering HALT:
  - Trigger: in RUN, not stalled, no redirect, and the fetched J target == pc.
  - That J is delivered normally; then state<=HALT and halted<=1.
- Enabled, behaviour in HALT:
  - pc holds, ifid_valid<=0, fetch_count holds, stall ignored.
  - redirect_valid: pc<=redirect_target, halted<=0, go to RUN.
  - rst also exits HALT.
- Disabled: halted is tied 0; a self-jump refetches every cycle, delivering the same J with ifid_valid=1 and fetch_count incrementing.

Test Plan:
- Reset: rst=1 for 3 cycles, then release -> pc=0, ifid_valid=0 through the BOOT cycle; ifid_valid=1 with ifid_pc=0 on the following edge.
- Sequential fetch: non-jump instructions -> ifid_pc=0,1,2,3 on consecutive cycles, fetch_count=4.
- Jump: pc=9, imem_data=32'h08000005 -> ifid_instr=32'h08000005, ifid_pc=9, next pc=5, no bubble.
- Redirect vs stall vs jump: stall=1, redirect_valid=1, redirect_target=8'h0A, imem_data is a J -> pc=8'h0A, ifid_valid=0; then stall=1 alone for 2 cycles -> pc and ifid hold.
- Wrap: pc=8'hFF, non-jump -> pc=8'h00, ifid_pc=8'hFF.
- Halt (macro on): pc=8'h3A, imem_data=32'h0800003A -> halted=1 on the next edge, pc stays 8'h3A, ifid_valid=0 afterwards; redirect to 8'h10 -> halted=0, fetch resumes at 8'h10. Macro off -> halted=0, ifid_valid stays 1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers IF/ID and resolves J locally with no bubble.
// Optional self-jump halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [5:0]         JUMP_OPCODE = 6'b000010
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              ifid_valid,
    output logic [15:0]       fetch_count,
    output logic              halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [15:0]       fetch_count_q, fetch_count_d;

    logic              is_jump;
    logic [ADDR_W-1:0] jump_target;

    assign is_jump     = (imem_data[DATA_W-1 -: 6] == JUMP_OPCODE);
    assign jump_target = imem_data[ADDR_W-1:0];

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q, halted_d;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
`ifdef FETCH_HALT_DETECT_EN
        halted_d      = halted_q;
`endif
        case (state_q)
            // Memory may still be settling from the reset edge, so nothing is fetched here.
            BOOT: begin
                state_d      = RUN;
                ifid_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d         = redirect_target;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                end else if (!stall) begin
                    ifid_instr_d  = imem_data;
                    ifid_pc_d     = pc_q;
                    ifid_valid_d  = 1'b1;
                    fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                                 : fetch_count_q + 16'd1;
                    if (is_jump) begin
                        pc_d = jump_target;
`ifdef FETCH_HALT_DETECT_EN
                        if (jump_target == pc_q) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end
`endif
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
`ifdef FETCH_HALT_DETECT_EN
            // Stall is deliberately ignored; only a redirect or reset leaves HALT.
            HALT: begin
                ifid_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d         = redirect_target;
                    ifid_instr_d = '0;
                    halted_d     = 1'b0;
                    state_d      = RUN;
                end
            end
`endif
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ifid_instr_q  <= '0;
            ifid_pc_q     <= '0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign imem_addr   = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
